spec_accumulator: RTL
=====================

// Module: spec_accumulator
// PURPOSE
//  Downstream consumer of the group controller's Capture_En and SPEC_Acc_Ctrl outputs.
//  Accumulates one spectrum of NBINS samples per laser pulse into a dual-port RAM:
//  - first pulse of a group: each bin is overwritten with the new sample;
//  - every later pulse: each bin is read, the sample is added, and the sum is written back.
//  A host-side read port exposes the accumulated spectrum between pulses.
// PARAMETERS
//  DATA_W  12    width of incoming ADC/bin sample
//  ACC_W   32    width of accumulated bin (ACC_W > DATA_W)
//  NBINS   1024  bins per pulse frame; must be >= 4
//  ADDR_W  10    address width, ceil(log2(NBINS))
// PORTS
//  clk            in   1       system clock
//  rst            in   1       synchronous active-high reset
//  capture_en     in   1       Capture_En from group control; frames accepted only when 1
//  spec_acc_ctrl  in   1       SPEC_Acc_Ctrl; 1 = add to RAM, 0 = overwrite (first pulse)
//  pulse_start    in   1       one-cycle strobe, start of a pulse frame
//  din_valid      in   1       sample qualifier
//  din            in   DATA_W  sample, unsigned, bins in ascending order
//  rd_en          in   1       host read request
//  rd_addr        in   ADDR_W  host read address
//  rd_data        out  ACC_W   accumulated bin value
//  rd_valid       out  1       rd_data valid
//  busy           out  1       frame in progress (ACCUM or DRAIN)
//  pulse_done     out  1       one-cycle strobe, last write of the frame committed
//  frame_err      out  1       sticky; cleared by rst only
//  sat_flag       out  1       sticky saturation indicator; cleared by rst only
// BEHAVIOUR
//  Reset: state IDLE; rd_data, rd_valid, busy, pulse_done, frame_err, sat_flag = 0;
//   bin counter = 0. RAM contents are not cleared.
//  FSM IDLE -> ACCUM -> DRAIN -> IDLE.
//  IDLE:
//   - pulse_start && capture_en: latch mode <= spec_acc_ctrl, clear bin counter, go to ACCUM.
//   - pulse_start && !capture_en: ignored.
//   - din_valid: ignored.
//  ACCUM, 2-stage read-modify-write pipeline:
//   - S1, on din_valid: RAM read at bin counter; register din and address; bin counter +1.
//   - S2: sum = mode ? ram_q + zero-extended din : zero-extended din; write to registered address.
//   - Reaching bin NBINS-1 moves the FSM to DRAIN.
//   - Gaps in din_valid are allowed; the pipeline advances only on valid.
//  DRAIN: 2 cycles to flush S2. pulse_done pulses for 1 cycle on the final write. Then IDLE.
//  Hazards: each address is written once per frame. NBINS >= 4 ensures a back-to-back
//   frame's read of bin 0 never overlaps the pending write of bin NBINS-1. No forwarding.
//  Boundary conditions:
//   - pulse_start while busy: ignored; frame_err <= 1.
//   - din_valid in DRAIN: dropped; frame_err <= 1.
//   - pulse_start in the same cycle busy drops: accepted as a new frame.
//   - rst mid-frame: returns to IDLE immediately. Partially written bins keep their values.
//     The next frame with spec_acc_ctrl = 0 fully overwrites them.
//  Host read:
//   - rd_en in IDLE: RAM read; rd_data and rd_valid are registered 1 cycle later.
//   - rd_en while busy: ignored; rd_valid stays 0.
//  busy is 1 from the cycle after an accepted pulse_start through the last DRAIN cycle.
// CONFIGURATION
//  SPEC_SAT_EN defined:
//   - the add saturates at 2**ACC_W-1;
//   - any clamp sets sat_flag.
//  SPEC_SAT_EN undefined:
//   - the add wraps modulo 2**ACC_W;
//   - sat_flag is tied to 0.
// STRUCTURE
//  Shared package spec_pkg:
//   - FSM state encoding (IDLE/ACCUM/DRAIN);
//   - default DATA_W/ACC_W/NBINS constants.
//  Sub-module spec_dpram:
//   - simple dual-port RAM, ACC_W x NBINS;
//   - 1 write port, 1 registered read port;
//   - read address muxed between the S1 bin counter (busy) and rd_addr (idle).
// TESTING  (bench: DATA_W=12, ACC_W=16, NBINS=8)
//  1 Overwrite: capture_en=1, spec_acc_ctrl=0, pulse_start, din=1..8
//    -> pulse_done once; host read bins 0..7 = 1..8.
//  2 Accumulate: repeat scenario 1 with spec_acc_ctrl=1, din=10 all bins
//    -> bins read 11..18; rd_valid 1 cycle after each rd_en.
//  3 Errors: pulse_start during ACCUM, then a 9th din_valid in DRAIN
//    -> frame_err=1; bins unaffected by the extra sample.
//  4 Saturation: bins preloaded near 0xFFF0, add 0xFFF accumulating
//    -> SPEC_SAT_EN: bins=0xFFFF, sat_flag=1; without it: bins wrap, sat_flag=0.
//  5 Gating and reset: capture_en=0 pulse_start -> busy stays 0;
//    rst at bin 3 -> IDLE next cycle, outputs 0; next overwrite frame correct.
//  6 Back-to-back frames (pulse_start on the DRAIN exit cycle), din_valid gaps, rd_en while busy
//    -> both frames correct; no rd_valid while busy.

Source files
------------

// File: rtl/spec_pkg.sv
// Shared definitions for the spectrum accumulator: FSM encoding and default sizes.
package spec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_ACC_W  = 32;
    localparam int DEF_NBINS  = 1024;
    localparam int DEF_ADDR_W = 10;

endpackage

// File: rtl/spec_dpram.sv
// Simple dual-port RAM holding the accumulated spectrum: one write port and
// one registered read port whose output register clears on reset.
module spec_dpram #(
    parameter int ACC_W  = 32,
    parameter int NBINS  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [ACC_W-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [ACC_W-1:0]  q
);

    logic [ACC_W-1:0] mem [NBINS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (re) q <= mem[raddr];
    end

endmodule

// File: rtl/spec_accumulator.sv
// Per-pulse spectrum accumulator with a 2-stage read-modify-write pipeline.
// Define SPEC_SAT_EN to saturate bin sums instead of wrapping.
module spec_accumulator
    import spec_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int NBINS  = DEF_NBINS,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_en,
    input  logic              spec_acc_ctrl,
    input  logic              pulse_start,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ACC_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              pulse_done,
    output logic              frame_err,
    output logic              sat_flag
);

    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NBINS - 1);

    state_t            state;
    logic              mode;
    logic              drain_last;
    logic [ADDR_W-1:0] bin_cnt;
    logic              s1_vld;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_din;
    logic [ACC_W-1:0]  ram_q;
    logic [ACC_W-1:0]  din_ext;
    logic [ACC_W-1:0]  sum;
    logic              s1_take;
    logic              host_rd;
    logic              accept;

    assign s1_take = (state == ACCUM) && din_valid;
    assign host_rd = (state == IDLE) && rd_en;
    // A new frame may start from IDLE or on the final DRAIN cycle.
    assign accept  = pulse_start && capture_en &&
                     ((state == IDLE) || ((state == DRAIN) && drain_last));
    assign din_ext = ACC_W'(s1_din);
    assign rd_data = ram_q;

    spec_dpram #(
        .ACC_W (ACC_W),
        .NBINS (NBINS),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (s1_vld),
        .waddr(s1_addr),
        .wdata(sum),
        .re   (s1_take || host_rd),
        .raddr((state == IDLE) ? rd_addr : bin_cnt),
        .q    (ram_q)
    );

`ifdef SPEC_SAT_EN
    logic [ACC_W:0] add_full;
    logic           ovf;

    always_comb begin
        add_full = {1'b0, ram_q} + {1'b0, din_ext};
        ovf      = mode && add_full[ACC_W];
        if (!mode)    sum = din_ext;
        else if (ovf) sum = '1;
        else          sum = add_full[ACC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst)                sat_flag <= 1'b0;
        else if (s1_vld && ovf) sat_flag <= 1'b1;
    end
`else
    always_comb sum = mode ? (ram_q + din_ext) : din_ext;

    assign sat_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mode       <= 1'b0;
            drain_last <= 1'b0;
            bin_cnt    <= '0;
            s1_vld     <= 1'b0;
            s1_addr    <= '0;
            s1_din     <= '0;
            busy       <= 1'b0;
            pulse_done <= 1'b0;
            frame_err  <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            pulse_done <= 1'b0;
            rd_valid   <= host_rd;
            s1_vld     <= s1_take;
            if (s1_take) begin
                s1_din  <= din;
                s1_addr <= bin_cnt;
                bin_cnt <= bin_cnt + ADDR_W'(1);
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        mode    <= spec_acc_ctrl;
                        bin_cnt <= '0;
                        state   <= ACCUM;
                        busy    <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (pulse_start) frame_err <= 1'b1;
                    if (s1_take && (bin_cnt == LAST_BIN)) begin
                        state      <= DRAIN;
                        drain_last <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (din_valid) frame_err <= 1'b1;
                    drain_last <= 1'b1;
                    // The last bin is written in the first DRAIN cycle.
                    if (!drain_last) begin
                        pulse_done <= 1'b1;
                        if (pulse_start) frame_err <= 1'b1;
                    end else if (accept) begin
                        mode    <= spec_acc_ctrl;
                        bin_cnt <= '0;
                        state   <= ACCUM;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
